coproc_cmd_if: RTL

//  CPU-side command initiator for the image coprocessor. Exposes a small memory-mapped register

---
 rtl/coproc_cmd_if.sv | 122 ++++++++++++
 1 files changed

// File: rtl/coproc_cmd_if.sv
// CPU-bus register front end that issues one start pulse per accepted GO and tracks the op to completion.
// 1-cycle read latency; GO while busy or while the coprocessor is not ready is rejected (STATUS.REJ).
module coproc_cmd_if #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  bus_addr,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        cp_start,
  output logic [2:0]  cp_func,
  output logic        cp_gray,
  output logic        cp_img_idx,
  input  logic        cp_rdy,
  input  logic        cp_done,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0]       ADDR_CMD    = 2'd0;
  localparam logic [1:0]       ADDR_STATUS = 2'd1;
  localparam logic [1:0]       ADDR_CYCLES = 2'd2;
  localparam logic [1:0]       ADDR_IRQEN  = 2'd3;
  localparam bit               TMO_EN      = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TMO_VAL     = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] cycles_q;
  logic             done_q;
  logic             st_done, st_tmo, st_rej;
  logic [1:0]       irq_en;

  logic             go, accept, rej_set, done_rise, ev_done, ev_tmo, w1c;
  logic [31:0]      status_word;

  always_comb begin
    go        = bus_we && (bus_addr == ADDR_CMD) && bus_wdata[31];
    accept    = go && (state == ST_IDLE) && cp_rdy;
    rej_set   = go && !accept;
    done_rise = cp_done && !done_q;
    // Done has priority over a timeout landing on the same cycle.
    ev_done   = (state == ST_WAIT) && done_rise;
    ev_tmo    = (state == ST_WAIT) && !done_rise && TMO_EN && (counter == TMO_VAL);
    w1c       = bus_we && (bus_addr == ADDR_STATUS);

    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (ev_done || ev_tmo) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    status_word = {27'd0, cp_rdy, st_rej, st_tmo, st_done, (state != ST_IDLE)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cp_start   <= 1'b0;
      cp_func    <= 3'd0;
      cp_gray    <= 1'b0;
      cp_img_idx <= 1'b0;
      counter    <= '0;
      cycles_q   <= '0;
      done_q     <= 1'b0;
      st_done    <= 1'b0;
      st_tmo     <= 1'b0;
      st_rej     <= 1'b0;
      irq_en     <= 2'b00;
      bus_rdata  <= 32'd0;
    end else begin
      state    <= state_nxt;
      cp_start <= (state_nxt == ST_ISSUE);
      done_q   <= cp_done;

      if (accept) begin
        cp_func    <= bus_wdata[2:0];
        cp_gray    <= bus_wdata[3];
        cp_img_idx <= bus_wdata[4];
        counter    <= '0;
      end else if (state == ST_WAIT && counter != CNT_MAX) begin
        counter <= counter + CNT_ONE;
      end

      if (ev_done || ev_tmo)
        cycles_q <= counter;

      // Hardware set beats a W1C on the same cycle.
      st_done <= ev_done || (st_done && !(w1c && bus_wdata[1]));
      st_tmo  <= ev_tmo  || (st_tmo  && !(w1c && bus_wdata[2]));
      st_rej  <= rej_set || (st_rej  && !(w1c && bus_wdata[3]));

      if (bus_we && bus_addr == ADDR_IRQEN)
        irq_en <= bus_wdata[1:0];

      if (bus_re) begin
        case (bus_addr)
          ADDR_STATUS: bus_rdata <= status_word;
          ADDR_CYCLES: bus_rdata <= 32'(cycles_q);
          ADDR_IRQEN:  bus_rdata <= {30'd0, irq_en};
          default:     bus_rdata <= 32'd0;
        endcase
      end
    end
  end

  assign irq = (st_done && irq_en[0]) || (st_tmo && irq_en[1]);

endmodule
